load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state encoding,
// and the funct3 legality check.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 inside {F3_SB, F3_SH, F3_SW};
        else
            return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte/halfword lane handling: load extraction with sign/zero extension,
// and read-modify-write merge of store data into the fetched word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        merged    = wdata;

        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase

        // Halfword lane is chosen by addr[1] alone; addr[0] never shifts the lane.
        case (funct3)
            F3_SB: begin
                merged = rdata;
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            F3_SH: begin
                merged = rdata;
                if (addr_lo[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-port load/store unit: word-only memory, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;

    logic        misaligned;
    logic        reject;
    logic [31:0] load_data;
    logic [31:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                     || ((req_funct3 == F3_LW) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign reject = !f3_legal(req_we, req_funct3) || misaligned;

    lsu_lane_align u_lane_align (
        .funct3    (funct3_q),
        .addr_lo   (addr_lo_q),
        .rdata     (mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            wdata_q    <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        funct3_q   <= req_funct3;
                        addr_lo_q  <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        if (reject) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else if (req_we && (req_funct3 == F3_SW)) begin
                            mem_write <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= req_wdata;
                            state     <= ST_WR;
                        end else begin
                            // Loads and SB/SH both fetch the containing word first.
                            mem_read <= 1'b1;
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    mem_read <= 1'b0;
                    state    <= ST_CAP;
                end
                ST_CAP: begin
                    if (we_q) begin
                        mem_write <= 1'b1;
                        mem_wdata <= merged;
                        state     <= ST_WR;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
